perf_counter_stream_reader: RTL and testbench
=============================================

Name: perf_counter_stream_reader

Overview:
- Reader side of the performance event counter bank: on request, snapshots all counter values plus the overflow map into a holding register.
- Serializes the snapshot as one AXI-Stream frame of fixed-width beats toward the AXI DMA.
- Sits between the counter bank and the DMA input. Counting continues undisturbed while a frame is being sent.

Parameters:
- NUM_COUNTERS, 115, number of counters and overflow bits.
- COUNTER_WIDTH, 7, bits per counter.
- DATA_WIDTH, 64, AXI-Stream tdata width. Must be >= 64.
- DROP_COUNT_WIDTH, 16, width of the dropped-request counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- counters_flat  input  NUM_COUNTERS*COUNTER_WIDTH  counter i occupies bits [i*COUNTER_WIDTH +: COUNTER_WIDTH]
- overflow_map  input  NUM_COUNTERS  sticky overflow bit per counter
- snapshot_req  input  1  single-cycle request to capture and send a frame
- busy  output  1  high while a frame is held or being sent
- drop_count  output  DROP_COUNT_WIDTH  number of requests rejected while busy
- m_axis_tdata  output  DATA_WIDTH  stream data
- m_axis_tvalid  output  1  stream valid
- m_axis_tready  input  1  stream ready
- m_axis_tlast  output  1  marks the last beat of a frame

Behaviour:
- Reset (asynchronous, rst_n low):
  - FSM goes to IDLE.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, drop_count=0, beat index=0.
  - Reset asserted mid-frame abandons the frame immediately. No tlast is emitted.
- Payload layout:
  - PAYLOAD_BITS = NUM_COUNTERS*COUNTER_WIDTH + NUM_COUNTERS.
  - Payload bit i*COUNTER_WIDTH+b = counter i bit b.
  - Payload bit NUM_COUNTERS*COUNTER_WIDTH+i = overflow_map[i].
  - Payload is zero-padded to NUM_BEATS*DATA_WIDTH, where NUM_BEATS = ceil(PAYLOAD_BITS/DATA_WIDTH).
  - Payload beat j carries padded payload bits [j*DATA_WIDTH +: DATA_WIDTH].
  - Defaults: 920 payload bits, 15 beats; the last beat has bits [63:24] zero.
- FSM states IDLE and SEND:
  - IDLE: snapshot_req=1 at edge t latches counters_flat and overflow_map, sets beat index 0, and enters SEND. From edge t+1: tvalid=1, tdata=beat 0, busy=1.
  - SEND: a handshake (tvalid&&tready at an edge) advances the beat index.
  - SEND: tdata, tlast and tvalid hold stable while tvalid&&!tready. tvalid never drops without a handshake.
  - SEND: tlast=1 only on the final beat. A handshake on the final beat returns the FSM to IDLE, and the next cycle shows tvalid=0 and busy=0.
- The snapshot is atomic: input changes after the capture edge do not affect the frame in flight.
- Rejected requests:
  - snapshot_req while in SEND is dropped, including in the cycle of the final handshake.
  - Each dropped request increments drop_count.
  - drop_count saturates at all-ones and does not wrap.
- Back-to-back frames: minimum one IDLE cycle between frames.
- tready is ignored while tvalid=0.
- Minimum frame duration with tready held high: NUM_BEATS cycles of tvalid.

Optional Feature:
- Macro: PEC_STREAM_HEADER_EN.
- When defined:
  - Adds a HEADER state entered on capture. A header beat is sent before payload beat 0.
  - Header fields:
    - [15:0] frame sequence number: starts at 0 after reset, increments after each completed frame, wraps at 16 bits.
    - [31:16] drop_count value, latched at the capture edge and saturated to 16 bits.
    - [47:32] NUM_BEATS.
    - Remaining bits zero.
  - The header follows the same stall rules as payload beats. The frame becomes NUM_BEATS+1 beats. tlast is still on the final payload beat only.
- When undefined: no header, no sequence register, and the frame is exactly NUM_BEATS beats.

Test Plan:
- Defaults, counter i = i mod 128, overflow_map bit 3 and bit 114 set, one snapshot_req, tready held 1 -> 15 consecutive beats starting the cycle after the request. Beat 0 = packed counters 0..9 (counter 9 contributes only its low bit). tlast on beat 14 only. Beat 14 bits [63:24] = 0.
- Same stimulus, tready toggling 1,0,0,1 repeatedly -> tdata and tlast stable during every stall, 15 handshakes total, reassembled payload identical to the first test.
- Change all counters_flat to all-ones during frame transmission -> the frame still carries the values captured at the request edge.
- snapshot_req pulsed at beats 2 and 7 and in the final-handshake cycle -> drop_count = 3, frame unaffected. A new request one cycle after busy falls starts a new frame.
- Assert rst_n=0 during beat 5 with tready=0 -> tvalid drops immediately, busy=0, drop_count=0. After release, a fresh request sends the full 15 beats from beat 0.
- With PEC_STREAM_HEADER_EN, two frames separated by 2 dropped requests -> frame 1 header = seq 0, drops 0, beats 15. Frame 2 header = seq 1, drops 2, beats 15. Each frame is 16 beats.

Source files
------------

// File: rtl/perf_counter_stream_reader.sv
// Snapshot reader for the event counter bank: captures counters plus
// overflow map and streams them as one AXI-Stream frame (PEC_STREAM_HEADER_EN adds a header beat).
module perf_counter_stream_reader #(
   parameter int NUM_COUNTERS     = 115,
   parameter int COUNTER_WIDTH    = 7,
   parameter int DATA_WIDTH       = 64,
   parameter int DROP_COUNT_WIDTH = 16
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [NUM_COUNTERS*COUNTER_WIDTH-1:0] counters_flat,
   input  logic [NUM_COUNTERS-1:0]               overflow_map,
   input  logic                                  snapshot_req,
   output logic                                  busy,
   output logic [DROP_COUNT_WIDTH-1:0]           drop_count,
   output logic [DATA_WIDTH-1:0]                 m_axis_tdata,
   output logic                                  m_axis_tvalid,
   input  logic                                  m_axis_tready,
   output logic                                  m_axis_tlast
);

   localparam int PAYLOAD_BITS = NUM_COUNTERS*COUNTER_WIDTH + NUM_COUNTERS;
   localparam int NUM_BEATS    = (PAYLOAD_BITS + DATA_WIDTH - 1) / DATA_WIDTH;
   localparam int FRAME_BITS   = NUM_BEATS * DATA_WIDTH;
   localparam int BEAT_W       = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
`ifdef PEC_STREAM_HEADER_EN
      HEADER = 2'd2,
`endif
      SEND   = 2'd1
   } state_t;

   state_t                state, state_nx;
   logic [FRAME_BITS-1:0] snap;
   logic [BEAT_W-1:0]     beat;
   logic                  hs;
   logic                  capture;
   logic                  last_hs;

   assign hs      = m_axis_tvalid & m_axis_tready;
   assign capture = (state == IDLE) & snapshot_req;
   assign last_hs = (state == SEND) & hs & (beat == LAST_BEAT);

   assign m_axis_tvalid = (state != IDLE);
   assign busy          = (state != IDLE);
   assign m_axis_tlast  = (state == SEND) & (beat == LAST_BEAT);

`ifdef PEC_STREAM_HEADER_EN
   logic [15:0] seq;
   logic [15:0] hdr_drop;
   logic [31:0] dc_ext;
   logic [15:0] drop_sat;

   assign dc_ext   = 32'(drop_count);
   assign drop_sat = (|dc_ext[31:16]) ? 16'hFFFF : dc_ext[15:0];

   assign m_axis_tdata =
      (state == HEADER) ? DATA_WIDTH'({16'(NUM_BEATS), hdr_drop, seq}) :
      (state == SEND)   ? snap[DATA_WIDTH-1:0] : '0;

   // Header fields: drop count frozen at capture, sequence bumps per frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seq      <= '0;
         hdr_drop <= '0;
      end else begin
         if (capture) hdr_drop <= drop_sat;
         if (last_hs) seq <= seq + 16'd1;
      end
   end
`else
   assign m_axis_tdata = (state == SEND) ? snap[DATA_WIDTH-1:0] : '0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
`ifdef PEC_STREAM_HEADER_EN
            if (snapshot_req) state_nx = HEADER;
`else
            if (snapshot_req) state_nx = SEND;
`endif
         end
`ifdef PEC_STREAM_HEADER_EN
         HEADER: if (hs) state_nx = SEND;
`endif
         SEND: if (last_hs) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Holding register shifts one beat down per payload handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap <= '0;
         beat <= '0;
      end else if (capture) begin
         snap <= FRAME_BITS'({overflow_map, counters_flat});
         beat <= '0;
      end else if ((state == SEND) && hs) begin
         snap <= snap >> DATA_WIDTH;
         beat <= (beat == LAST_BEAT) ? '0 : beat + BEAT_W'(1);
      end
   end

   // Saturating count of requests arriving while a frame is in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_count <= '0;
      end else if (snapshot_req && (state != IDLE) && (drop_count != '1)) begin
         drop_count <= drop_count + DROP_COUNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_perf_counter_stream_reader.sv
// Randomized self-checking bench for perf_counter_stream_reader.
// Reference payload is rebuilt bit by bit from the layout rules.
module tb_perf_counter_stream_reader;

   localparam int NC = 115;
   localparam int CW = 7;
   localparam int DW = 64;
   localparam int DCW = 16;
   localparam int PB = NC*CW + NC;
   localparam int NB = (PB + DW - 1) / DW;

   logic            clk = 0;
   logic            rst_n = 0;
   logic [NC*CW-1:0] counters_flat = '0;
   logic [NC-1:0]   overflow_map = '0;
   logic            snapshot_req = 0;
   logic            busy;
   logic [DCW-1:0]  drop_count;
   logic [DW-1:0]   m_axis_tdata;
   logic            m_axis_tvalid;
   logic            m_axis_tready = 0;
   logic            m_axis_tlast;

   perf_counter_stream_reader dut (
      .clk(clk),
      .rst_n(rst_n),
      .counters_flat(counters_flat),
      .overflow_map(overflow_map),
      .snapshot_req(snapshot_req),
      .busy(busy),
      .drop_count(drop_count),
      .m_axis_tdata(m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [CW-1:0] cnt [NC];
   logic          ovf [NC];
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] got_q [$];
   int            exp_drops = 0;
   int            exp_seq = 0;
   logic [DW-1:0] first_payload [$];

   task automatic pack();
      for (int i = 0; i < NC; i++) begin
         counters_flat[i*CW +: CW] = cnt[i];
         overflow_map[i] = ovf[i];
      end
   endtask

   task automatic set_default_pattern();
      for (int i = 0; i < NC; i++) begin
         cnt[i] = CW'(i % 128);
         ovf[i] = (i == 3) || (i == 114);
      end
      pack();
   endtask

   task automatic build_expected();
      logic [DW-1:0] w;
      int p;
      exp_q.delete();
`ifdef PEC_STREAM_HEADER_EN
      w = '0;
      w[15:0]  = 16'(exp_seq);
      w[31:16] = (exp_drops > 65535) ? 16'hFFFF : 16'(exp_drops);
      w[47:32] = 16'(NB);
      exp_q.push_back(w);
`endif
      for (int j = 0; j < NB; j++) begin
         w = '0;
         for (int b = 0; b < DW; b++) begin
            p = j*DW + b;
            if (p < NC*CW) w[b] = cnt[p / CW][p % CW];
            else if (p < PB) w[b] = ovf[p - NC*CW];
         end
         exp_q.push_back(w);
      end
   endtask

   task automatic send_req();
      snapshot_req = 1;
      build_expected();
      @(negedge clk);
      snapshot_req = 0;
      checks++;
      if (m_axis_tvalid !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL start_latency tvalid=%b busy=%b exp 1 1",
                  m_axis_tvalid, busy);
      end
   endtask

   task automatic rx_frame(input int mode, input int drop_mask,
                           input bit corrupt, input int stop_at);
      int idx = 0;
      int cyc = 0;
      int nexp = exp_q.size();
      bit stall = 0;
      bit done = 0;
      logic [DW-1:0] pd = '0;
      logic pl = 0;
      got_q.delete();
      while (!done && cyc < 2000) begin
         snapshot_req = 0;
         case (mode)
            0: m_axis_tready = 1;
            1: m_axis_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: m_axis_tready = 1'($urandom_range(0, 1));
         endcase
         if (stop_at >= 0 && idx == stop_at) begin
            m_axis_tready = 0;
            break;
         end
         checks++;
         if (m_axis_tvalid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL valid_hold idx=%0d tvalid=%b busy=%b exp 1 1",
                     idx, m_axis_tvalid, busy);
         end
         if (stall) begin
            checks++;
            if (m_axis_tdata !== pd || m_axis_tlast !== pl) begin
               errors++;
               $display("FAIL stall_stable idx=%0d data=%h last=%b exp %h %b",
                        idx, m_axis_tdata, m_axis_tlast, pd, pl);
            end
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (drop_mask[idx]) begin
               snapshot_req = 1;
               if (exp_drops < (1 << DCW) - 1) exp_drops++;
            end
            checks++;
            if (m_axis_tdata !== exp_q[idx] ||
                m_axis_tlast !== (idx == nexp - 1)) begin
               errors++;
               $display("FAIL beat%0d data=%h last=%b exp %h %b", idx,
                        m_axis_tdata, m_axis_tlast, exp_q[idx],
                        (idx == nexp - 1));
            end
            got_q.push_back(m_axis_tdata);
            if (idx == nexp - 1) done = 1;
            idx++;
            if (corrupt && idx == 1) begin
               counters_flat = '1;
               overflow_map = '1;
            end
         end
         stall = m_axis_tvalid && !m_axis_tready;
         pd = m_axis_tdata;
         pl = m_axis_tlast;
         @(negedge clk);
         cyc++;
      end
      snapshot_req = 0;
      if (stop_at < 0) begin
         checks++;
         if (!done) begin
            errors++;
            $display("FAIL frame_timeout beats=%0d exp %0d", idx, nexp);
         end else begin
            exp_seq = (exp_seq + 1) % 65536;
         end
         checks++;
         if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_end tvalid=%b busy=%b exp 0 0",
                     m_axis_tvalid, busy);
         end
         checks++;
         if (drop_count !== DCW'(exp_drops)) begin
            errors++;
            $display("FAIL drop_count got %0d exp %0d", drop_count, exp_drops);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 0;
      m_axis_tready = 1;
      repeat (2) @(negedge clk);
      checks++;
      if (m_axis_tvalid !== 0 || m_axis_tlast !== 0 || m_axis_tdata !== '0 ||
          busy !== 0 || drop_count !== '0) begin
         errors++;
         $display("FAIL reset v=%b l=%b d=%h b=%b dc=%0d exp all 0",
                  m_axis_tvalid, m_axis_tlast, m_axis_tdata, busy, drop_count);
      end
      rst_n = 1;
      @(negedge clk);
      checks++;
      if (m_axis_tvalid !== 0 || busy !== 0) begin
         errors++;
         $display("FAIL idle_ready tvalid=%b busy=%b exp 0 0", m_axis_tvalid, busy);
      end
   endtask

   task automatic test_basic();
      set_default_pattern();
      send_req();
      rx_frame(0, 0, 0, -1);
      first_payload = got_q;
      checks++;
      if (got_q.size() == exp_q.size() &&
          got_q[got_q.size()-1][63:24] !== 40'd0) begin
         errors++;
         $display("FAIL last_pad got %h exp 0", got_q[got_q.size()-1][63:24]);
      end
   endtask

   task automatic test_stall();
      set_default_pattern();
      send_req();
      rx_frame(1, 0, 0, -1);
      checks++;
      if (got_q != first_payload) begin
         errors++;
         $display("FAIL stall_reassembly beats=%0d exp %0d",
                  got_q.size(), first_payload.size());
      end
   endtask

   task automatic test_atomic();
      set_default_pattern();
      send_req();
      rx_frame(0, 0, 1, -1);
      pack();
   endtask

   task automatic test_drops_back_to_back();
      set_default_pattern();
      send_req();
      rx_frame(0, (1 << 2) | (1 << 7) | (1 << (exp_q.size() - 1)), 0, -1);
      send_req();
      rx_frame(0, 0, 0, -1);
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < NC; i++) begin
            cnt[i] = CW'($urandom_range(0, 127));
            ovf[i] = 1'($urandom_range(0, 1));
         end
         pack();
         send_req();
         rx_frame(2, int'($urandom_range(0, 65535)) & 32'hFFFE, 0, -1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
   endtask

   task automatic test_midframe_reset();
      set_default_pattern();
      send_req();
      rx_frame(0, 1 << 2, 0, 5);
      #2 rst_n = 0;
      #1;
      checks++;
      if (m_axis_tvalid !== 0 || m_axis_tlast !== 0 || busy !== 0 ||
          drop_count !== '0) begin
         errors++;
         $display("FAIL midframe_reset v=%b l=%b b=%b dc=%0d exp 0 0 0 0",
                  m_axis_tvalid, m_axis_tlast, busy, drop_count);
      end
      exp_drops = 0;
      exp_seq = 0;
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      send_req();
      rx_frame(0, 0, 0, -1);
   endtask

   task automatic test_header_pair();
      set_default_pattern();
      send_req();
      rx_frame(0, (1 << 3) | (1 << 9), 0, -1);
      @(negedge clk);
      send_req();
      rx_frame(1, 0, 0, -1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_atomic();
      test_drops_back_to_back();
      test_random();
      test_midframe_reset();
      test_header_pair();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
